rscl_alu_arb: RTL



---
 rtl/rscl_alu_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rscl_alu_arb.sv
// Two-port round-robin arbiter sharing one combinational RV32 ALU, with a registered
// valid/ready result stage. Optional counters are enabled by RSCL_ALU_ARB_STATS_EN.

module rscl_alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic [DATA_W-1:0] res_o
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sra_s;
  logic [DATA_W-1:0]        sra_u;
  logic [4:0]               shamt;
  logic                     alt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[4:0];
  // Only the exact alternate encoding selects SUB/SRA; other funct7 values fall back to ADD/SRL.
  assign alt   = (funct7_i == 7'h20);
  // Kept in its own signal so the arithmetic shift is not forced unsigned by a mixed ternary.
  assign sra_s = a_s >>> shamt;
  assign sra_u = sra_s;

  always_comb begin
    res_o = '0;
    unique case (funct3_i)
      3'd0: res_o = alt ? (a_i - b_i) : (a_i + b_i);
      3'd1: res_o = a_i << shamt;
      3'd2: res_o = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      3'd3: res_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      3'd4: res_o = a_i ^ b_i;
      3'd5: res_o = alt ? sra_u : (a_i >> shamt);
      3'd6: res_o = a_i | b_i;
      3'd7: res_o = a_i & b_i;
    endcase
  end

endmodule

module rscl_alu_arb #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_out,
  output logic        resp_src
`ifdef RSCL_ALU_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_conflict
`endif
);

  localparam int DATA_W = 32;

  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_out_q, resp_out_d;
  logic              resp_src_q, resp_src_d;
  logic              ptr_q, ptr_d;

  logic              can_accept;
  logic              gnt_any;
  logic              gnt_sel;
  logic              xfer;
  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic [2:0]        op_f3;
  logic [6:0]        op_f7;

  // Stage 0: arbitration and operand mux feeding the shared ALU
  assign can_accept = !resp_valid_q || resp_ready;
  assign gnt_any    = req0_valid || req1_valid;
  // On contention the pointer decides; otherwise the lone valid requester wins.
  assign gnt_sel    = (req0_valid && req1_valid) ? ptr_q : req1_valid;

  assign req0_ready = !rst && can_accept && gnt_any && !gnt_sel;
  assign req1_ready = !rst && can_accept && gnt_any &&  gnt_sel;
  assign xfer       = req0_ready || req1_ready;

  assign op_a  = gnt_sel ? req1_val1   : req0_val1;
  assign op_b  = gnt_sel ? req1_val2   : req0_val2;
  assign op_f3 = gnt_sel ? req1_funct3 : req0_funct3;
  assign op_f7 = gnt_sel ? req1_funct7 : req0_funct7;

  rscl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .funct3_i (op_f3),
    .funct7_i (op_f7),
    .res_o    (alu_res)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_out_d   = resp_out_q;
    resp_src_d   = resp_src_q;
    ptr_d        = ptr_q;
    if (xfer) begin
      resp_valid_d = 1'b1;
      resp_out_d   = alu_res;
      resp_src_d   = gnt_sel;
      ptr_d        = !gnt_sel;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Stage 1: result register
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_out_q   <= '0;
      resp_src_q   <= 1'b0;
      ptr_q        <= RR_INIT;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      resp_src_q   <= resp_src_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_src   = resp_src_q;

`ifdef RSCL_ALU_ARB_STATS_EN
  logic [31:0] stat_g0_q, stat_g0_d;
  logic [31:0] stat_g1_q, stat_g1_d;
  logic [31:0] stat_cf_q, stat_cf_d;

  always_comb begin
    stat_g0_d = stat_g0_q + {31'b0, req0_ready};
    stat_g1_d = stat_g1_q + {31'b0, req1_ready};
    stat_cf_d = stat_cf_q + {31'b0, (req0_valid && req1_valid && can_accept)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_g0_q <= '0;
      stat_g1_q <= '0;
      stat_cf_q <= '0;
    end else begin
      stat_g0_q <= stat_g0_d;
      stat_g1_q <= stat_g1_d;
      stat_cf_q <= stat_cf_d;
    end
  end

  assign stat_grant0   = stat_g0_q;
  assign stat_grant1   = stat_g1_q;
  assign stat_conflict = stat_cf_q;
`endif

endmodule
